// File: rtl/cfg_pkg.sv
// Shared types and CRC helper for the configuration chain loader.
package cfg_pkg;

    localparam int          CFG_WORD_W = 32;
    localparam logic [15:0] CRC16_POLY = 16'h1021;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CRC  = 2'd2,
        DONE = 2'd3
    } cfg_state_t;

    // One bit of CRC-16-CCITT, MSB-first, non-reflected.
    function automatic logic [15:0] crc16_bit(input logic [15:0] crc, input logic in_bit);
        logic fb;
        fb = crc[15] ^ in_bit;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/cfg_word_serializer.sv
// Shift register plus one-word prefetch; turns accepted stream words into an MSB-first bit stream.
module cfg_word_serializer
    import cfg_pkg::*;
(
    input  logic                  prog_clk,
    input  logic                  prog_rst,
    input  logic                  fetch_en,
    input  logic                  flush,
    input  logic [CFG_WORD_W-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  bit_valid,
    output logic                  bit_value
);

    localparam int MSB = CFG_WORD_W - 1;

    logic [CFG_WORD_W-1:0] sr;
    logic [CFG_WORD_W-1:0] pf;
    logic                  sr_valid;
    logic                  pf_valid;
    logic [4:0]            sr_idx;
    logic                  out_bit;
    logic                  sr_last;
    logic                  sr_free;
    logic                  take;

    assign sr_last   = sr_valid && (sr_idx == 5'd31);
    assign sr_free   = !sr_valid || sr_last;
    assign s_ready   = fetch_en && !pf_valid;
    assign take      = s_ready && s_valid;
    assign bit_valid = sr_valid;
    assign bit_value = out_bit;

    // out_bit tracks sr[MSB] whenever sr is valid and holds its value across stalls.
    always_ff @(posedge prog_clk or posedge prog_rst) begin
        if (prog_rst) begin
            sr       <= '0;
            pf       <= '0;
            sr_valid <= 1'b0;
            pf_valid <= 1'b0;
            sr_idx   <= '0;
            out_bit  <= 1'b0;
        end else if (flush) begin
            sr_valid <= 1'b0;
            pf_valid <= 1'b0;
            sr_idx   <= '0;
        end else begin
            if (sr_free && pf_valid) begin
                sr       <= pf;
                sr_valid <= 1'b1;
                sr_idx   <= '0;
                out_bit  <= pf[MSB];
                pf_valid <= 1'b0;
            end else if (sr_valid) begin
                sr     <= {sr[MSB-1:0], 1'b0};
                sr_idx <= sr_idx + 5'd1;
                if (sr_last) begin
                    sr_valid <= 1'b0;
                end else begin
                    out_bit <= sr[MSB-1];
                end
            end
            if (take) begin
                pf       <= s_data;
                pf_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cfg_chain_loader.sv
// Streams a configuration bitstream into a fabric row's scan chain, then checks a trailing CRC-16 word.
//   state | meaning
//   IDLE  | waiting for start
//   LOAD  | fetching words and shifting CHAIN_LEN bits into the row
//   CRC   | waiting for the trailing CRC word
//   DONE  | one-cycle completion, done=1
module cfg_chain_loader
    import cfg_pkg::*;
#(
    parameter int          CHAIN_LEN = 512,
    parameter int          WORD_W    = 32,
    parameter logic [15:0] CRC_INIT  = 16'hFFFF
) (
    input  logic              prog_clk,
    input  logic              prog_rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              prog_out,
    output logic              prog_en,
    output logic              busy,
    output logic              done,
    output logic              crc_err,
    output logic [15:0]       bit_count
);

    localparam int          N_WORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam logic [11:0] WORDS_INIT = 12'(N_WORDS);
    localparam logic [15:0] CHAIN_END  = 16'(CHAIN_LEN);
    localparam logic [15:0] LAST_BIT   = 16'(CHAIN_LEN - 1);

    if (WORD_W != CFG_WORD_W) begin : g_word_w_chk
        $error("cfg_chain_loader: WORD_W must be %0d", CFG_WORD_W);
    end
    if (CHAIN_LEN < 1 || CHAIN_LEN > 65535) begin : g_chain_len_chk
        $error("cfg_chain_loader: CHAIN_LEN out of range 1..65535");
    end

    cfg_state_t  state;
    logic [11:0] words_left;
    logic [15:0] crc;
    logic        ser_ready;
    logic        bit_valid;
    logic        bit_value;
    logic        fetch_en;
    logic        shift;
    logic        last_shift;
    logic        flush;
    logic        take;

    // words_left counts down the words still to fetch; fetching stops at zero.
    assign fetch_en   = (state == LOAD) && (words_left != 12'd0);
    assign shift      = (state == LOAD) && bit_valid && (bit_count != CHAIN_END);
    assign last_shift = shift && (bit_count == LAST_BIT);
    assign flush      = (state == LOAD) && (abort || last_shift);
    assign take       = ser_ready && s_valid;
    assign s_ready    = ser_ready || (state == CRC);
    assign prog_en    = bit_valid;
    assign prog_out   = bit_value;

    cfg_word_serializer u_ser (
        .prog_clk  (prog_clk),
        .prog_rst  (prog_rst),
        .fetch_en  (fetch_en),
        .flush     (flush),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (ser_ready),
        .bit_valid (bit_valid),
        .bit_value (bit_value)
    );

    always_ff @(posedge prog_clk or posedge prog_rst) begin
        if (prog_rst) begin
            state      <= IDLE;
            words_left <= '0;
            crc        <= CRC_INIT;
            crc_err    <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            bit_count  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= LOAD;
                        busy       <= 1'b1;
                        bit_count  <= '0;
                        crc_err    <= 1'b0;
                        crc        <= CRC_INIT;
                        words_left <= WORDS_INIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (take) begin
                            words_left <= words_left - 12'd1;
                        end
                        if (shift) begin
                            bit_count <= bit_count + 16'd1;
                            crc       <= crc16_bit(crc, bit_value);
                        end
                        if (last_shift) begin
                            state <= CRC;
                        end
                    end
                end
                CRC: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (s_valid) begin
                        crc_err <= (s_data[15:0] != crc);
                        state   <= DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench for cfg_chain_loader: a 40-bit instance for most scenarios and a 64-bit instance for the word-count boundary.
module tb_cfg_chain_loader;

    logic clk;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic        rst_40, start_40, abort_40, s_valid_40;
    logic [31:0] s_data_40;
    logic        s_ready_40, prog_out_40, prog_en_40, busy_40, done_40, crc_err_40;
    logic [15:0] bit_count_40;

    logic        rst_64, start_64, abort_64, s_valid_64;
    logic [31:0] s_data_64;
    logic        s_ready_64, prog_out_64, prog_en_64, busy_64, done_64, crc_err_64;
    logic [15:0] bit_count_64;

    cfg_chain_loader #(.CHAIN_LEN(40), .WORD_W(32), .CRC_INIT(16'hFFFF)) dut40 (
        .prog_clk(clk), .prog_rst(rst_40), .start(start_40), .abort(abort_40),
        .s_data(s_data_40), .s_valid(s_valid_40), .s_ready(s_ready_40),
        .prog_out(prog_out_40), .prog_en(prog_en_40), .busy(busy_40), .done(done_40),
        .crc_err(crc_err_40), .bit_count(bit_count_40)
    );

    cfg_chain_loader #(.CHAIN_LEN(64), .WORD_W(32), .CRC_INIT(16'hFFFF)) dut64 (
        .prog_clk(clk), .prog_rst(rst_64), .start(start_64), .abort(abort_64),
        .s_data(s_data_64), .s_valid(s_valid_64), .s_ready(s_ready_64),
        .prog_out(prog_out_64), .prog_en(prog_en_64), .busy(busy_64), .done(done_64),
        .crc_err(crc_err_64), .bit_count(bit_count_64)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [31:0] w0, w1;
    logic [39:0] exp40;
    logic [15:0] gold40;

    bit          mon_on = 1'b0;
    logic [39:0] cap;
    int          en_cycles, en_runs, first_en, done_n, done_cyc;
    logic        prev_en;
    logic [15:0] stall_bc[$];
    int          hs0, hs1, hs_crc;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Observe the 40-bit instance on the falling edge.
    initial forever begin
        @(negedge clk);
        if (mon_on) begin
            if (prog_en_40) begin
                cap = {cap[38:0], prog_out_40};
                en_cycles++;
                if (!prev_en) begin
                    en_runs++;
                    if (first_en < 0) first_en = cyc;
                end
            end else if (busy_40 && en_cycles > 0 && en_cycles < 40) begin
                stall_bc.push_back(bit_count_40);
            end
            if (done_40) begin
                done_n++;
                done_cyc = cyc;
            end
            prev_en = prog_en_40;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] crc_ref(input logic [63:0] v, input int nbytes);
        logic [15:0] c;
        logic [7:0]  b;
        c = 16'hFFFF;
        for (int i = nbytes - 1; i >= 0; i--) begin
            b = v[i*8 +: 8];
            c = c ^ {b, 8'h00};
            for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    // Entered on a falling edge; returns on the falling edge after the handshake.
    task automatic send_word(input logic [31:0] w, output int hs, output bit to);
        to = 1'b1;
        hs = -1;
        s_data_40  = w;
        s_valid_40 = 1'b1;
        for (int i = 0; i < 200 && to; i++) begin
            if (s_ready_40) begin
                hs = cyc;
                to = 1'b0;
            end
            @(negedge clk);
        end
        s_valid_40 = 1'b0;
    endtask

    task automatic clear_mon();
        cap = '0; en_cycles = 0; en_runs = 0; first_en = -1;
        done_n = 0; done_cyc = -1; prev_en = 1'b0;
        stall_bc.delete();
    endtask

    task automatic do_load(input logic [31:0] crc_word, input int gap, output bit to);
        bit t0, t1, t2, tw;
        clear_mon();
        mon_on = 1'b1;
        start_40 = 1'b1;
        @(negedge clk);
        start_40 = 1'b0;
        send_word(w0, hs0, t0);
        tw = 1'b0;
        if (gap >= 0) begin
            tw = 1'b1;
            for (int i = 0; i < 200 && tw; i++) begin
                if (prog_en_40 === 1'b0 && bit_count_40 == 16'd32) tw = 1'b0;
                else @(negedge clk);
            end
            repeat (gap) @(negedge clk);
        end
        send_word(w1, hs1, t1);
        send_word(crc_word, hs_crc, t2);
        repeat (3) @(negedge clk);
        mon_on = 1'b0;
        to = t0 | t1 | t2 | tw;
    endtask

    task automatic test_reset();
        rst_40 = 1'b1; rst_64 = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (s_ready_40 !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready got %b exp 0", s_ready_40); end
        n_checks++; if (prog_en_40 !== 1'b0) begin n_fail++; $display("FAIL reset_prog_en got %b exp 0", prog_en_40); end
        n_checks++; if (prog_out_40 !== 1'b0) begin n_fail++; $display("FAIL reset_prog_out got %b exp 0", prog_out_40); end
        n_checks++; if ({busy_40, done_40, crc_err_40} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {busy_40, done_40, crc_err_40}); end
        n_checks++; if (bit_count_40 !== 16'd0) begin n_fail++; $display("FAIL reset_bit_count got %0d exp 0", bit_count_40); end
        n_checks++; if ({s_ready_64, prog_en_64, busy_64, bit_count_64} !== 19'd0) begin n_fail++; $display("FAIL reset_dut64 got %h exp 0", {s_ready_64, prog_en_64, busy_64, bit_count_64}); end
        rst_40 = 1'b0; rst_64 = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (s_ready_40 !== 1'b0) begin n_fail++; $display("FAIL idle_s_ready got %b exp 0", s_ready_40); end
    endtask

    task automatic test_basic();
        bit to;
        do_load({16'h0000, gold40}, -1, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL t1_timeout got %b exp 0", to); end
        n_checks++; if (en_cycles != 40) begin n_fail++; $display("FAIL t1_en_cycles got %0d exp 40", en_cycles); end
        n_checks++; if (en_runs != 1) begin n_fail++; $display("FAIL t1_en_runs got %0d exp 1", en_runs); end
        n_checks++; if (cap !== exp40) begin n_fail++; $display("FAIL t1_bits got %h exp %h", cap, exp40); end
        n_checks++; if (first_en - hs0 != 2) begin n_fail++; $display("FAIL t1_latency got %0d exp 2", first_en - hs0); end
        n_checks++; if (done_n != 1) begin n_fail++; $display("FAIL t1_done_count got %0d exp 1", done_n); end
        n_checks++; if (done_cyc - hs_crc != 1) begin n_fail++; $display("FAIL t1_done_delay got %0d exp 1", done_cyc - hs_crc); end
        n_checks++; if (crc_err_40 !== 1'b0) begin n_fail++; $display("FAIL t1_crc_err got %b exp 0", crc_err_40); end
        n_checks++; if (bit_count_40 !== 16'd40) begin n_fail++; $display("FAIL t1_bit_count got %0d exp 40", bit_count_40); end
        n_checks++; if (busy_40 !== 1'b0) begin n_fail++; $display("FAIL t1_busy_after got %b exp 0", busy_40); end
    endtask

    task automatic test_bad_crc();
        bit to;
        do_load(32'h0000_0000, -1, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL t2_timeout got %b exp 0", to); end
        n_checks++; if (done_n != 1) begin n_fail++; $display("FAIL t2_done_count got %0d exp 1", done_n); end
        n_checks++; if (crc_err_40 !== 1'b1) begin n_fail++; $display("FAIL t2_crc_err got %b exp 1", crc_err_40); end
        start_40 = 1'b1;
        @(negedge clk);
        start_40 = 1'b0;
        n_checks++; if (crc_err_40 !== 1'b0) begin n_fail++; $display("FAIL t2_crc_err_clear got %b exp 0", crc_err_40); end
        n_checks++; if (busy_40 !== 1'b1) begin n_fail++; $display("FAIL t2_busy_start got %b exp 1", busy_40); end
        abort_40 = 1'b1;
        @(negedge clk);
        abort_40 = 1'b0;
        n_checks++; if (busy_40 !== 1'b0) begin n_fail++; $display("FAIL t2_busy_abort got %b exp 0", busy_40); end
    endtask

    task automatic test_starve();
        bit to;
        bit bc_ok;
        do_load({16'h0000, gold40}, 3, to);
        bc_ok = 1'b1;
        foreach (stall_bc[i]) if (stall_bc[i] !== 16'd32) bc_ok = 1'b0;
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL t3_timeout got %b exp 0", to); end
        n_checks++; if (stall_bc.size() != 5) begin n_fail++; $display("FAIL t3_stall_cycles got %0d exp 5", stall_bc.size()); end
        n_checks++; if (bc_ok !== 1'b1) begin n_fail++; $display("FAIL t3_stall_bit_count got not-frozen exp 32"); end
        n_checks++; if (en_runs != 2) begin n_fail++; $display("FAIL t3_en_runs got %0d exp 2", en_runs); end
        n_checks++; if (en_cycles != 40) begin n_fail++; $display("FAIL t3_en_cycles got %0d exp 40", en_cycles); end
        n_checks++; if (cap !== exp40) begin n_fail++; $display("FAIL t3_bits got %h exp %h", cap, exp40); end
        n_checks++; if (crc_err_40 !== 1'b0 || done_n != 1) begin n_fail++; $display("FAIL t3_completion got err=%b done=%0d exp err=0 done=1", crc_err_40, done_n); end
    endtask

    task automatic test_abort();
        bit t0, t1, to, found;
        clear_mon();
        mon_on = 1'b1;
        start_40 = 1'b1;
        @(negedge clk);
        start_40 = 1'b0;
        send_word(w0, hs0, t0);
        send_word(w1, hs1, t1);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (bit_count_40 == 16'd17) found = 1'b1;
            else @(negedge clk);
        end
        n_checks++; if (found !== 1'b1 || t0 || t1) begin n_fail++; $display("FAIL t4_reach_17 got found=%b exp 1", found); end
        abort_40 = 1'b1;
        @(posedge clk);
        #1 abort_40 = 1'b0;
        @(negedge clk);
        n_checks++; if (prog_en_40 !== 1'b0) begin n_fail++; $display("FAIL t4_prog_en got %b exp 0", prog_en_40); end
        n_checks++; if (busy_40 !== 1'b0) begin n_fail++; $display("FAIL t4_busy got %b exp 0", busy_40); end
        n_checks++; if (bit_count_40 !== 16'd17) begin n_fail++; $display("FAIL t4_bit_count got %0d exp 17", bit_count_40); end
        n_checks++; if (s_ready_40 !== 1'b0) begin n_fail++; $display("FAIL t4_s_ready got %b exp 0", s_ready_40); end
        repeat (4) @(negedge clk);
        mon_on = 1'b0;
        n_checks++; if (done_n != 0) begin n_fail++; $display("FAIL t4_no_done got %0d exp 0", done_n); end
        do_load({16'h0000, gold40}, -1, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL t4_reload_timeout got %b exp 0", to); end
        n_checks++; if (cap !== exp40 || en_cycles != 40) begin n_fail++; $display("FAIL t4_reload_bits got %h/%0d exp %h/40", cap, en_cycles, exp40); end
        n_checks++; if (done_n != 1 || crc_err_40 !== 1'b0 || bit_count_40 !== 16'd40) begin n_fail++; $display("FAIL t4_reload_done got done=%0d err=%b bc=%0d exp 1/0/40", done_n, crc_err_40, bit_count_40); end
    endtask

    task automatic test_reset_mid();
        bit t0, found;
        int ready_seen;
        start_40 = 1'b1;
        @(negedge clk);
        start_40 = 1'b0;
        send_word(w0, hs0, t0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (bit_count_40 == 16'd10) found = 1'b1;
            else @(negedge clk);
        end
        n_checks++; if (found !== 1'b1 || prog_out_40 !== 1'b1) begin n_fail++; $display("FAIL t5_setup got found=%b out=%b exp 1/1", found, prog_out_40); end
        #1 rst_40 = 1'b1;
        #1;
        n_checks++; if ({s_ready_40, prog_out_40, prog_en_40} !== 3'b000) begin n_fail++; $display("FAIL t5_async_io got %b exp 000", {s_ready_40, prog_out_40, prog_en_40}); end
        n_checks++; if ({busy_40, done_40, crc_err_40} !== 3'b000) begin n_fail++; $display("FAIL t5_async_flags got %b exp 000", {busy_40, done_40, crc_err_40}); end
        n_checks++; if (bit_count_40 !== 16'd0) begin n_fail++; $display("FAIL t5_async_bit_count got %0d exp 0", bit_count_40); end
        @(negedge clk);
        rst_40 = 1'b0;
        s_data_40  = w1;
        s_valid_40 = 1'b1;
        ready_seen = 0;
        repeat (4) begin
            if (s_ready_40 !== 1'b0) ready_seen++;
            @(negedge clk);
        end
        s_valid_40 = 1'b0;
        n_checks++; if (ready_seen != 0) begin n_fail++; $display("FAIL t5_s_ready_idle got %0d ready cycles exp 0", ready_seen); end
        start_40 = 1'b1;
        @(negedge clk);
        start_40 = 1'b0;
        n_checks++; if (s_ready_40 !== 1'b1) begin n_fail++; $display("FAIL t5_s_ready_after_start got %b exp 1", s_ready_40); end
        abort_40 = 1'b1;
        @(negedge clk);
        abort_40 = 1'b0;
    endtask

    task automatic test_chain64();
        logic [31:0] words[3];
        logic [63:0] exp64, cap64;
        logic [15:0] g64, bc_at_crc;
        int          en64, runs64, k, done_n64;
        logic        prev, hs;
        bit          fin;
        exp64 = {32'h1234_5678, 32'h9ABC_DEF0};
        g64   = crc_ref(exp64, 8);
        words[0] = 32'h1234_5678;
        words[1] = 32'h9ABC_DEF0;
        words[2] = {16'hBEEF, g64};
        cap64 = '0; en64 = 0; runs64 = 0; k = 0; done_n64 = 0; prev = 1'b0; bc_at_crc = '0; fin = 1'b0;
        start_64 = 1'b1;
        @(negedge clk);
        start_64 = 1'b0;
        s_data_64  = words[0];
        s_valid_64 = 1'b1;
        for (int i = 0; i < 300 && !fin; i++) begin
            if (prog_en_64) begin
                cap64 = {cap64[62:0], prog_out_64};
                en64++;
                if (!prev) runs64++;
            end
            prev = prog_en_64;
            if (done_64) begin
                done_n64++;
                fin = 1'b1;
            end
            hs = s_valid_64 && s_ready_64;
            if (hs) begin
                if (k == 2) bc_at_crc = bit_count_64;
                k++;
            end
            @(posedge clk);
            #1;
            if (hs) begin
                if (k < 3) s_data_64 = words[k];
                else s_valid_64 = 1'b0;
            end
            @(negedge clk);
        end
        s_valid_64 = 1'b0;
        n_checks++; if (fin !== 1'b1) begin n_fail++; $display("FAIL t6_done_seen got %b exp 1", fin); end
        n_checks++; if (k != 3) begin n_fail++; $display("FAIL t6_handshakes got %0d exp 3", k); end
        n_checks++; if (bc_at_crc !== 16'd64) begin n_fail++; $display("FAIL t6_crc_word_at got bit_count %0d exp 64", bc_at_crc); end
        n_checks++; if (en64 != 64 || runs64 != 1) begin n_fail++; $display("FAIL t6_en got %0d cycles %0d runs exp 64/1", en64, runs64); end
        n_checks++; if (cap64 !== exp64) begin n_fail++; $display("FAIL t6_bits got %h exp %h", cap64, exp64); end
        n_checks++; if (crc_err_64 !== 1'b0) begin n_fail++; $display("FAIL t6_crc_err got %b exp 0", crc_err_64); end
    endtask

    initial begin
        rst_40 = 1'b1; start_40 = 1'b0; abort_40 = 1'b0; s_valid_40 = 1'b0; s_data_40 = '0;
        rst_64 = 1'b1; start_64 = 1'b0; abort_64 = 1'b0; s_valid_64 = 1'b0; s_data_64 = '0;
        w0     = 32'hA5A5_0F0F;
        w1     = 32'hC300_0000;
        exp40  = {32'hA5A5_0F0F, 8'hC3};
        gold40 = crc_ref({24'h000000, exp40}, 5);
        clear_mon();

        test_reset();
        test_basic();
        test_bad_crc();
        test_starve();
        test_abort();
        test_reset_mid();
        test_chain64();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cfg_chain_loader.md
Name: cfg_chain_loader

Overview:
- Configuration loader sitting directly upstream of a fabric row's programming scan chain.
- Accepts the bitstream as 32-bit words over a valid/ready stream, serialises them MSB-first onto the row's prog_in, and gates shifting with prog_en.
- Counts exactly CHAIN_LEN bits, then consumes one trailing CRC word and flags a mismatch.
- Every shift happens on prog_clk. The row's cells shift only while prog_en=1, so stalls are bubble-safe.

Parameters:
- CHAIN_LEN, 512: total configuration bits in the downstream chain. Range 1..65535.
- WORD_W, 32: stream word width. Fixed at 32; present for documentation and checks only.
- CRC_INIT, 16'hFFFF: CRC-16-CCITT seed. Polynomial is 0x1021, non-reflected, no final XOR.

Ports:
- prog_clk  in  1  programming clock; all state is on its rising edge
- prog_rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begins a load (IDLE or DONE only)
- abort  in  1  one-cycle pulse; cancels a load in progress
- s_data  in  32  bitstream word; bit 31 is shifted first
- s_valid  in  1  s_data valid
- s_ready  out  1  loader accepts s_data this cycle
- prog_out  out  1  serial bit to the row's prog_in
- prog_en  out  1  shift enable to the row
- busy  out  1  load in progress (LOAD or CRC state)
- done  out  1  one-cycle pulse at load completion
- crc_err  out  1  sticky CRC mismatch from the last completed load; cleared on start
- bit_count  out  16  bits shifted so far in the current load

Behaviour:
- Reset values: s_ready=0, prog_out=0, prog_en=0, busy=0, done=0, crc_err=0, bit_count=0. FSM returns to IDLE and both word registers are empty. Reset mid-load takes effect immediately; there is no completion pulse.
- FSM states:
  - IDLE: start → LOAD, clears bit_count, crc_err and the CRC register to CRC_INIT.
  - LOAD: when bit_count reaches CHAIN_LEN → CRC.
  - CRC: on a CRC-word handshake → DONE.
  - DONE: one cycle, done=1, then → IDLE.
  - start in any state other than IDLE/DONE is ignored.
- Datapath: a 32-bit shift register (SR) plus a one-word prefetch register (PF), each with its own valid flag.
  - s_ready=1 in LOAD when PF is empty and the remaining bits not yet fetched are greater than 0.
  - A handshake loads PF. PF moves into SR in the same cycle that SR empties.
- Shift cycle: in LOAD with SR valid:
  - prog_en=1 and prog_out=SR[31]. These are registered outputs, so bits appear on the same cycle SR holds them.
  - SR shifts left, bit_count increments, and the CRC updates with the bit just shifted.
- Stall: if SR is empty (upstream starved), prog_en=0 and prog_out holds its last value. No bit is counted.
- Back-to-back words with s_valid held high produce a continuous prog_en=1 run with no bubbles. First-word latency is 2 cycles from handshake to first prog_en=1.
- Final word: only CHAIN_LEN mod 32 bits are shifted (32 if the remainder is 0). The remaining low bits are discarded. Words fetched = ceil(CHAIN_LEN/32).
- CRC state:
  - prog_en=0 and s_ready=1.
  - On handshake, s_data[15:0] is compared with the CRC register; crc_err is set on mismatch. s_data[31:16] is ignored.
- abort in LOAD or CRC:
  - Next cycle: state=IDLE, prog_en=0, SR/PF empty, no done pulse.
  - bit_count keeps its value for debug. The chain contents are undefined.
- start and abort in the same cycle while in IDLE: start wins. abort in IDLE/DONE is a no-op.
- bit_count saturates at CHAIN_LEN and never wraps.

Decomposition:
- Shared package cfg_pkg:
  - FSM state enum (IDLE, LOAD, CRC, DONE)
  - CRC16_POLY=16'h1021
  - function crc16_bit(crc, bit)
  - CFG_WORD_W=32
- One natural sub-module, cfg_word_serializer: SR+PF, the handshake and bit emission, reporting bit_valid/bit_value to the parent. The parent owns the FSM, counters and CRC.

Test Plan:
- Test 1, CHAIN_LEN=40, continuous stream:
  - start, then words 32'hA5A5_0F0F, 32'hC3000000, then CRC word = golden CRC of the 40 bits.
  - Expect prog_en high for exactly 40 contiguous cycles and prog_out sequence = 1010_0101… then 1100_0011.
  - Expect done one cycle after the CRC handshake, crc_err=0, bit_count=40.
- Test 2, wrong CRC: same as Test 1 but CRC word 32'h0000_0000 → crc_err=1 after done. A following start clears crc_err to 0.
- Test 3, starvation: s_valid=0 for 5 cycles between word 1 and word 2 → prog_en drops for exactly those stall cycles, bit_count frozen at 32, total shifted bits still 40.
- Test 4, abort: abort at bit_count=17 → next cycle prog_en=0, busy=0, no done pulse. A new start completes a clean 40-bit load.
- Test 5, reset mid-operation: assert prog_rst asynchronously mid-word → all outputs reach reset values without a clock edge; s_ready=0 until the next start.
- Test 6, CHAIN_LEN=64 with s_valid held high: exactly 2 data words accepted, then the CRC word. A third data word offered is taken only as the CRC word, and its low half is compared.
